// File: rtl/wb_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_pipe_if
// Description : Valid/ready handshake bundle carrying NCH register-write
//               channels (enable, address, data) per entry.
//               master drives valid and payload and receives ready;
//               slave receives valid and payload and drives ready.
//               Channel k is packed at [k*ADDR_W +: ADDR_W] and
//               [k*DATA_W +: DATA_W].
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NCH    = 1
);
    logic                  valid;
    logic                  ready;
    logic [NCH-1:0]        w_enable;
    logic [NCH*ADDR_W-1:0] w_addr;
    logic [NCH*DATA_W-1:0] w_data;

    modport master (
        output valid,
        output w_enable,
        output w_addr,
        output w_data,
        input  ready
    );

    modport slave (
        input  valid,
        input  w_enable,
        input  w_addr,
        input  w_data,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/wb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_pipe_stage
// Description : Two-entry skid-buffer pipeline stage for register write-back
//               traffic. The head register drives the outputs and the skid
//               register absorbs one extra entry, so in_ready is a flop and
//               there is no combinational path from out_ready to in_ready.
//               Writes to register 0 are suppressed at capture time.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset
//               flush     - discard held and incoming entries
//               in_bus    - upstream handshake + payload (slave)
//               out_bus   - downstream handshake + head payload (master)
//               occupancy - number of held entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NCH    = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        flush,
    wb_pipe_if.slave         in_bus,
    wb_pipe_if.master        out_bus,
    output logic [1:0]       occupancy
);

    localparam int AW_TOT = NCH * ADDR_W;
    localparam int DW_TOT = NCH * DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic                in_ready_q,  in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [NCH-1:0]      head_en_q,   head_en_d;
    logic [AW_TOT-1:0]   head_addr_q, head_addr_d;
    logic [DW_TOT-1:0]   head_data_q, head_data_d;
    logic [NCH-1:0]      skid_en_q,   skid_en_d;
    logic [AW_TOT-1:0]   skid_addr_q, skid_addr_d;
    logic [DW_TOT-1:0]   skid_data_q, skid_data_d;

    logic                w_accept;
    logic                w_release;
    logic                w_load_head_in;
    logic                w_load_head_skid;
    logic                w_load_skid;
    logic [NCH-1:0]      w_cap_en;

    // A write to register 0 is architecturally a no-op, so its enable is
    // dropped on the way in; address and data still travel unchanged.
    for (genvar k = 0; k < NCH; k++) begin : g_zero_sup
        assign w_cap_en[k] = in_bus.w_enable[k] &&
                             (in_bus.w_addr[k*ADDR_W +: ADDR_W] != '0);
    end

    assign w_accept  = in_bus.valid && in_ready_q;
    assign w_release = out_valid_q && out_bus.ready;

    always_comb begin
        state_d          = state_q;
        head_en_d        = head_en_q;
        head_addr_d      = head_addr_q;
        head_data_d      = head_data_q;
        skid_en_d        = skid_en_q;
        skid_addr_d      = skid_addr_q;
        skid_data_d      = skid_data_q;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;

        if (flush) begin
            // A release this cycle is still considered taken downstream;
            // an entry offered this cycle is simply never captured.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d        = ST_ONE;
                        w_load_head_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_release) begin
                        w_load_head_in = 1'b1;
                    end else if (w_accept) begin
                        state_d     = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_release) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a release can happen.
                    if (w_release) begin
                        state_d          = ST_ONE;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Payload flops only toggle on a real capture or skid-to-head move.
        if (w_load_head_in) begin
            head_en_d   = w_cap_en;
            head_addr_d = in_bus.w_addr;
            head_data_d = in_bus.w_data;
        end else if (w_load_head_skid) begin
            head_en_d   = skid_en_q;
            head_addr_d = skid_addr_q;
            head_data_d = skid_data_q;
        end

        if (w_load_skid) begin
            skid_en_d   = w_cap_en;
            skid_addr_d = in_bus.w_addr;
            skid_data_d = in_bus.w_data;
        end

        // An empty stage must never present a live write enable.
        if (state_d == ST_EMPTY) begin
            head_en_d = '0;
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_en_q   <= '0;
            head_addr_q <= '0;
            head_data_q <= '0;
            skid_en_q   <= '0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_en_q   <= head_en_d;
            head_addr_q <= head_addr_d;
            head_data_q <= head_data_d;
            skid_en_q   <= skid_en_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_bus.ready     = in_ready_q;
    assign out_bus.valid    = out_valid_q;
    assign out_bus.w_enable = head_en_q;
    assign out_bus.w_addr   = head_addr_q;
    assign out_bus.w_data   = head_data_q;
    assign occupancy        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_pipe_stage
// Description : Directed self-checking bench for wb_pipe_stage with two
//               write channels (32-bit data, 5-bit address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_pipe_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NCH    = 2;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] occupancy;
    int         checks;
    int         failures;

    wb_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH)) in_bus ();
    wb_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH)) out_bus ();

    wb_pipe_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NCH    (NCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_bus    (in_bus),
        .out_bus   (out_bus),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  en;
        logic [9:0]  addr;
        logic [63:0] data;
    } entry_t;

    entry_t exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [1:0] en,
                         input logic [4:0] a1, input logic [4:0] a0,
                         input logic [31:0] d1, input logic [31:0] d0);
        in_bus.valid    = v;
        in_bus.w_enable = en;
        in_bus.w_addr   = {a1, a0};
        in_bus.w_data   = {d1, d0};
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] en,
                           input logic [9:0] addr, input logic [63:0] data,
                           input logic [1:0] occ, input logic rdy);
        chk({tag, "_valid"}, 64'(out_bus.valid), 64'(v));
        chk({tag, "_en"},    64'(out_bus.w_enable), 64'(en));
        chk({tag, "_addr"},  64'(out_bus.w_addr), 64'(addr));
        chk({tag, "_data"},  out_bus.w_data, data);
        chk({tag, "_occ"},   64'(occupancy), 64'(occ));
        chk({tag, "_rdy"},   64'(in_bus.ready), 64'(rdy));
    endtask

    initial begin
        entry_t e;
        entry_t got;
        checks   = 0;
        failures = 0;

        // Reset with a valid entry on the input: it must be ignored.
        rst           = 1'b1;
        flush         = 1'b0;
        out_bus.ready = 1'b1;
        offer(1'b1, 2'b11, 5'd4, 5'd6, 32'hAAAA_0001, 32'hBBBB_0002);
        tick();
        tick();
        chk_out("reset", 1'b0, 2'b00, 10'd0, 64'd0, 2'd0, 1'b1);
        rst = 1'b0;
        offer(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk_out("idle", 1'b0, 2'b00, 10'd0, 64'd0, 2'd0, 1'b1);

        // Single entry, one-cycle latency.
        offer(1'b1, 2'b01, 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF);
        tick();
        chk_out("single", 1'b1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEAD_BEEF}, 2'd1, 1'b1);
        offer(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        // Released to empty: enable cleared, addr/data held.
        chk_out("drain", 1'b0, 2'b00, {5'd0, 5'd5}, {32'h0, 32'hDEAD_BEEF}, 2'd0, 1'b1);

        // Back-pressure: A, B, C offered while downstream stalls.
        out_bus.ready = 1'b0;
        offer(1'b1, 2'b01, 5'd0, 5'd1, 32'h0, 32'hA);
        tick();
        chk_out("bp_a", 1'b1, 2'b01, {5'd0, 5'd1}, {32'h0, 32'hA}, 2'd1, 1'b1);
        offer(1'b1, 2'b01, 5'd0, 5'd2, 32'h0, 32'hB);
        tick();
        chk_out("bp_b", 1'b1, 2'b01, {5'd0, 5'd1}, {32'h0, 32'hA}, 2'd2, 1'b0);
        offer(1'b1, 2'b01, 5'd0, 5'd3, 32'h0, 32'hC);
        tick();
        chk_out("bp_c_hold", 1'b1, 2'b01, {5'd0, 5'd1}, {32'h0, 32'hA}, 2'd2, 1'b0);
        out_bus.ready = 1'b1;
        tick();
        chk_out("bp_out_b", 1'b1, 2'b01, {5'd0, 5'd2}, {32'h0, 32'hB}, 2'd1, 1'b1);
        tick();
        chk_out("bp_out_c", 1'b1, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hC}, 2'd1, 1'b1);
        offer(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk_out("bp_empty", 1'b0, 2'b00, {5'd0, 5'd3}, {32'h0, 32'hC}, 2'd0, 1'b1);

        // Zero-register suppression, per channel, in both directions.
        offer(1'b1, 2'b11, 5'd7, 5'd0, 32'hCAFE_F00D, 32'h1234_5678);
        tick();
        chk_out("zero_ch0", 1'b1, 2'b10, {5'd7, 5'd0}, {32'hCAFE_F00D, 32'h1234_5678}, 2'd1, 1'b1);
        offer(1'b1, 2'b11, 5'd0, 5'd3, 32'h5555_AAAA, 32'h0BAD_CAFE);
        tick();
        chk_out("zero_ch1", 1'b1, 2'b01, {5'd0, 5'd3}, {32'h5555_AAAA, 32'h0BAD_CAFE}, 2'd1, 1'b1);
        offer(1'b1, 2'b10, 5'd9, 5'd8, 32'h2, 32'h1);
        tick();
        chk_out("en_ch1_only", 1'b1, 2'b10, {5'd9, 5'd8}, {32'h2, 32'h1}, 2'd1, 1'b1);
        offer(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("zero_drain_valid", 64'(out_bus.valid), 64'd0);

        // Flush from FULL with an entry offered in the same cycle.
        out_bus.ready = 1'b0;
        offer(1'b1, 2'b11, 5'd1, 5'd2, 32'h11, 32'h22);
        tick();
        offer(1'b1, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44);
        tick();
        chk("flush_pre_occ", 64'(occupancy), 64'd2);
        flush = 1'b1;
        offer(1'b1, 2'b11, 5'd9, 5'd9, 32'h99, 32'h99);
        tick();
        chk_out("flush", 1'b0, 2'b00, {5'd1, 5'd2}, {32'h11, 32'h22}, 2'd0, 1'b1);
        flush = 1'b0;
        offer(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        out_bus.ready = 1'b1;
        tick();
        chk("flush_gone_valid", 64'(out_bus.valid), 64'd0);
        chk("flush_gone_occ", 64'(occupancy), 64'd0);

        // Reset while FULL.
        out_bus.ready = 1'b0;
        offer(1'b1, 2'b01, 5'd0, 5'd6, 32'h0, 32'h66);
        tick();
        offer(1'b1, 2'b01, 5'd0, 5'd7, 32'h0, 32'h77);
        tick();
        chk("rst_pre_occ", 64'(occupancy), 64'd2);
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        chk_out("rst_mid", 1'b0, 2'b00, 10'd0, 64'd0, 2'd0, 1'b1);
        rst   = 1'b0;
        flush = 1'b0;
        offer(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        out_bus.ready = 1'b1;
        tick();
        chk("rst_post_valid", 64'(out_bus.valid), 64'd0);

        // Streaming: 100 random entries, one out per cycle.
        for (int i = 0; i < 100; i++) begin
            e.en   = 2'($urandom_range(0, 3));
            e.addr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31))};
            e.data = {32'($urandom), 32'($urandom)};
            offer(1'b1, e.en, e.addr[9:5], e.addr[4:0], e.data[63:32], e.data[31:0]);
            e.en[0] = e.en[0] && (e.addr[4:0] != 5'd0);
            e.en[1] = e.en[1] && (e.addr[9:5] != 5'd0);
            exp_q.push_back(e);
            tick();
            got = exp_q.pop_front();
            chk("stream_valid", 64'(out_bus.valid), 64'd1);
            chk("stream_ready", 64'(in_bus.ready), 64'd1);
            chk("stream_en",    64'(out_bus.w_enable), 64'(got.en));
            chk("stream_addr",  64'(out_bus.w_addr), 64'(got.addr));
            chk("stream_data",  out_bus.w_data, got.data);
        end
        offer(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("stream_end_valid", 64'(out_bus.valid), 64'd0);
        chk("stream_end_en", 64'(out_bus.w_enable), 64'd0);
        chk("stream_end_q", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_pipe_stage.md
WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

Parameters
REQ-001 DATA_W, default 32, width of one register write-data channel.
REQ-002 ADDR_W, default 5, width of one register write-address channel.
REQ-003 NCH, default 1, number of independent write channels carried per entry (1..4).

Interface
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  discard all held and incoming entries.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_w_enable  input  NCH  per-channel write enable.
REQ-010 in_w_addr  input  NCH*ADDR_W  per-channel destination register; channel k in bits [k*ADDR_W +: ADDR_W].
REQ-011 in_w_data  input  NCH*DATA_W  per-channel write data, same packing.
REQ-012 out_valid  output  1  entry presented downstream.
REQ-013 out_ready  input  1  downstream accepts the entry.
REQ-014 out_w_enable / out_w_addr / out_w_data  output  NCH / NCH*ADDR_W / NCH*DATA_W  head-entry payload.
REQ-015 occupancy  output  2  number of held entries (0..2).

Function
REQ-016 Accept when in_valid && in_ready; release when out_valid && out_ready; both evaluated in the same cycle.
REQ-017 Storage is a 2-entry skid buffer: head register (drives outputs) and skid register; no combinational path from out_ready to in_ready.
REQ-018 in_ready SHALL be a registered signal equal to (occupancy < 2) after the current cycle's updates.
REQ-019 States: EMPTY (0), ONE (1), FULL (2); occupancy output equals the state encoding.
REQ-020 EMPTY: accept -> ONE, entry into head.
REQ-021 ONE: accept and release -> ONE, new entry into head; accept only -> FULL, new entry into skid; release only -> EMPTY.
REQ-022 FULL: in_ready=0, so no accept; release -> ONE, skid moves to head; otherwise hold.
REQ-023 Latency: an entry accepted into EMPTY is visible on outputs with out_valid=1 the following cycle.
REQ-024 Order preserved: entries leave in acceptance order; none is duplicated or dropped except by flush or rst.
REQ-025 Zero-register suppression: at capture, channel k's stored enable = in_w_enable[k] && (in_w_addr[k] != 0); addr and data are stored unchanged.
REQ-026 When out_valid=0, out_w_enable SHALL be all-zero; out_w_addr/out_w_data hold their last value.
REQ-027 Channels are independent; enable/addr/data of channel k never affect channel j.
REQ-028 flush=1: next cycle EMPTY, occupancy 0, out_valid 0, in_ready 1; an entry offered in the flush cycle is discarded; a release in the flush cycle still counts as taken by downstream.
REQ-029 flush and rst together: rst behaviour applies.
REQ-030 Payload registers update only on accept or skid-to-head move, to save power.

Reset
REQ-031 rst=1 at a rising edge: occupancy 0, out_valid 0, in_ready 1, out_w_enable 0, out_w_addr 0, out_w_data 0, skid contents 0.
REQ-032 Reset mid-operation (any state) discards all entries with no partial output on the next cycle.
REQ-033 While rst=1, in_valid is ignored.

Verification
REQ-034 NCH=1: reset, then in_valid=1, addr=5, data=0xDEADBEEF, enable=1, out_ready=1 -> next cycle out_valid=1, out_w_addr=5, out_w_data=0xDEADBEEF, out_w_enable=1, occupancy=1.
REQ-035 out_ready=0, offer entries A (addr 1), B (addr 2), C (addr 3) back-to-back -> A in head, B in skid, occupancy=2, in_ready=0 and C not accepted; then out_ready=1 for 3 cycles with C held -> outputs A, B, C in order.
REQ-036 addr=0, enable=1, data=0x12345678 -> out_valid=1, out_w_enable=0, out_w_addr=0, out_w_data=0x12345678.
REQ-037 FULL state, then flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_w_enable=0, in_ready=1; offered entry never appears.
REQ-038 NCH=2: ch0 addr=3 enable=1, ch1 addr=0 enable=1 -> out_w_enable=2'b01, both addr/data passed unchanged.
REQ-039 Streaming with out_ready=1 every cycle, 100 random entries -> one output per cycle after 1-cycle latency, order and payload match a reference queue, in_ready never deasserts.
